// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: states, ASCII constants and target encoding shared by the UART command parser.
package uart_cmd_pkg;
  typedef enum logic [1:0] {IDLE, GET_ARG, EXEC, ERR} state_t;
  typedef enum logic [1:0] {TGT_HOUR, TGT_MIN, TGT_SEC} tgt_t;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] CH_R = "R";
  localparam logic [7:0] CH_C = "C";
  localparam logic [7:0] CH_X = "X";
  localparam logic [7:0] CH_H = "H";
  localparam logic [7:0] CH_M = "M";
  localparam logic [7:0] CH_S = "S";
  localparam logic [7:0] CH_0 = "0";
  localparam logic [7:0] CH_9 = "9";
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= "a" && c <= "z") ? c - 8'h20 : c;
  endfunction
endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte idle counter; expired flags the last allowed idle cycle.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes ASCII command bytes into registered one-cycle control pulses.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ARG_DIGITS     = 2,
  parameter int ARG_W          = 7,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CASE_INSENS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_run,
  output logic             o_clear,
  output logic             o_mode,
  output logic             o_hour,
  output logic             o_min,
  output logic             o_sec,
  output logic             o_set_hour,
  output logic             o_set_min,
  output logic             o_set_sec,
  output logic [ARG_W-1:0] o_arg,
  output logic             o_err
);
  localparam int CW = $clog2(ARG_DIGITS + 1);
  localparam logic [CW-1:0] MAX_DIGITS = CW'(ARG_DIGITS);
  state_t state;
  tgt_t tgt;
  logic [ARG_W-1:0] acc;
  logic [CW-1:0] cnt;
  logic [7:0] ch;
  logic accept, is_digit, eol, expired;
  assign accept = i_rx_valid && o_rx_ready;
  assign ch = (CASE_INSENS != 0) ? to_upper(i_rx_data) : i_rx_data;
  assign is_digit = ch >= CH_0 && ch <= CH_9;
  assign eol = ch == CR || ch == LF;
  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .clr(accept), .en(state == GET_ARG), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tgt <= TGT_HOUR;
      acc <= '0;
      cnt <= '0;
      o_arg <= '0;
      o_rx_ready <= 1'b1;
      {o_run, o_clear, o_mode, o_hour, o_min, o_sec, o_set_hour, o_set_min, o_set_sec, o_err} <= '0;
    end else begin
      {o_run, o_clear, o_mode, o_hour, o_min, o_sec, o_set_hour, o_set_min, o_set_sec, o_err} <= '0;
      o_rx_ready <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          if (ch == CH_R || ch == CH_C || ch == CH_X) begin
            o_run <= ch == CH_R;
            o_clear <= ch == CH_C;
            o_mode <= ch == CH_X;
            state <= EXEC;
            o_rx_ready <= 1'b0;
          end else if (ch == CH_H || ch == CH_M || ch == CH_S) begin
            tgt <= ch == CH_H ? TGT_HOUR : ch == CH_M ? TGT_MIN : TGT_SEC;
            acc <= '0;
            cnt <= '0;
            state <= GET_ARG;
          end else if (!(eol || ch == SP)) begin
            o_err <= 1'b1;
            state <= ERR;
            o_rx_ready <= 1'b0;
          end
        end
        GET_ARG: if (accept) begin
          if (is_digit && cnt < MAX_DIGITS) begin
            acc <= ARG_W'((ARG_W+4)'(acc) * (ARG_W+4)'(10) + (ARG_W+4)'(ch[3:0]));
            cnt <= cnt + 1'b1;
          end else if (eol) begin
            o_hour <= cnt == '0 && tgt == TGT_HOUR;
            o_min <= cnt == '0 && tgt == TGT_MIN;
            o_sec <= cnt == '0 && tgt == TGT_SEC;
            o_set_hour <= cnt != '0 && tgt == TGT_HOUR;
            o_set_min <= cnt != '0 && tgt == TGT_MIN;
            o_set_sec <= cnt != '0 && tgt == TGT_SEC;
            o_arg <= cnt != '0 ? acc : o_arg;
            state <= EXEC;
            o_rx_ready <= 1'b0;
          end else begin
            o_err <= 1'b1;
            state <= ERR;
            o_rx_ready <= 1'b0;
          end
        end else if (expired) begin
          o_err <= 1'b1;
          state <= ERR;
          o_rx_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized command streams checked against a decimal command model.
module tb_uart_cmd_parser;
  localparam int T = 16;
  localparam int P_RUN = 9, P_HR = 6, P_SH = 3, P_ERR = 0;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, rx_valid2 = 0;
  logic rdy, rdy2;
  logic [9:0] p, p2;
  logic [6:0] arg, arg2;
  int n_assert = 0, n_fail = 0;
  uart_cmd_parser #(.ARG_DIGITS(2), .ARG_W(7), .TIMEOUT_CYCLES(T), .CASE_INSENS(1)) dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rdy),
    .o_run(p[9]), .o_clear(p[8]), .o_mode(p[7]), .o_hour(p[6]), .o_min(p[5]), .o_sec(p[4]),
    .o_set_hour(p[3]), .o_set_min(p[2]), .o_set_sec(p[1]), .o_arg(arg), .o_err(p[0])
  );
  uart_cmd_parser #(.ARG_DIGITS(2), .ARG_W(7), .TIMEOUT_CYCLES(T), .CASE_INSENS(0)) dut2 (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid2), .o_rx_ready(rdy2),
    .o_run(p2[9]), .o_clear(p2[8]), .o_mode(p2[7]), .o_hour(p2[6]), .o_min(p2[5]), .o_sec(p2[4]),
    .o_set_hour(p2[3]), .o_set_min(p2[2]), .o_set_sec(p2[1]), .o_arg(arg2), .o_err(p2[0])
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [9:0] pb(input int i);
    return 10'(1) << i;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (!rdy && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (w == 8) chk("ready_wait", 32'(rdy), 1);
    rx_data = b;
    rx_valid = 1;
    @(posedge clk);
    #1 rx_valid = 0;
  endtask
  task automatic expect_out(input string tag, input logic [9:0] ep, input logic [6:0] ea, input logic er);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(p), 32'(ep));
    chk({tag, "_arg"}, 32'(arg), 32'(ea));
    chk({tag, "_ready"}, 32'(rdy), 32'(er));
  endtask
  initial begin
    logic [7:0] cmds [6] = '{"R", "C", "X", "H", "M", "S"};
    logic [7:0] bad [4] = '{"Q", "Z", "!", "5"};
    logic [7:0] ws [3] = '{8'h20, 8'h0D, 8'h0A};
    logic [6:0] exp_arg;
    int k;
    repeat (2) @(negedge clk);
    chk("reset_pulse", 32'(p), 0);
    chk("reset_arg", 32'(arg), 0);
    chk("reset_ready", 32'(rdy), 1);
    rst = 0;
    send("r");
    expect_out("lc_run", pb(P_RUN), 0, 0);
    send("S"); expect_out("s_cmd", 0, 0, 1);
    send("4"); expect_out("s_d4", 0, 0, 1);
    send("2"); expect_out("s_d2", 0, 0, 1);
    send(8'h0D); expect_out("set_sec42", pb(P_SH - 2), 42, 0);
    repeat (10) @(negedge clk);
    chk("arg_held", 32'(arg), 42);
    send("h"); expect_out("h_cmd", 0, 42, 1);
    send(8'h0D); expect_out("bare_hour", pb(P_HR), 42, 0);
    send("M"); send("1"); send("2");
    send("3"); expect_out("overflow", pb(P_ERR), 42, 0);
    send("C"); expect_out("clear", pb(P_RUN - 1), 42, 0);
    send("H"); send("5");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (p == 0 && k < T + 8);
    chk("timeout_pulse", 32'(p), 32'(pb(P_ERR)));
    chk("timeout_latency", k, T + 1);
    send("H"); send("5");
    repeat (T - 1) @(posedge clk);
    send(8'h0A); expect_out("byte_on_expiry", pb(P_SH), 5, 0);
    send("Q"); expect_out("bad_q", pb(P_ERR), 5, 0);
    @(negedge clk);
    rx_data = "x"; rx_valid2 = 1;
    @(posedge clk);
    #1 rx_valid2 = 0;
    @(negedge clk);
    chk("cs_lower_err", 32'(p2), 32'(pb(P_ERR)));
    chk("cs_lower_ready", 32'(rdy2), 0);
    @(negedge clk);
    rx_data = "X"; rx_valid2 = 1;
    @(posedge clk);
    #1 rx_valid2 = 0;
    @(negedge clk);
    chk("cs_upper_mode", 32'(p2), 32'(pb(P_RUN - 2)));
    send("S"); send("7");
    @(negedge clk);
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_pulse", 32'(p), 0);
    end
    chk("rst_mid_arg", 32'(arg), 0);
    chk("rst_mid_ready", 32'(rdy), 1);
    rst = 0;
    repeat (T + 4) begin
      @(negedge clk);
      chk("after_rst_quiet", 32'(p), 0);
    end
    exp_arg = 0;
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 7);
      logic [7:0] c;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (kind < 6) begin
        c = cmds[kind];
        if ($urandom_range(0, 1) == 1) c = c | 8'h20;
        send(c);
      end
      if (kind < 3) expect_out("rnd_cmd", pb(P_RUN - kind), exp_arg, 0);
      else if (kind < 6) begin
        int nd = $urandom_range(0, 3);
        int val = 0;
        expect_out("rnd_tgt", 0, exp_arg, 1);
        for (int d = 0; d < nd; d++) begin
          int dg = $urandom_range(0, 9);
          send(8'(dg) + "0");
          if (d == 2) expect_out("rnd_ovf", pb(P_ERR), exp_arg, 0);
          else begin
            val = val * 10 + dg;
            expect_out("rnd_digit", 0, exp_arg, 1);
          end
        end
        if (nd < 3) begin
          send($urandom_range(0, 1) == 1 ? 8'h0D : 8'h0A);
          if (nd == 0) expect_out("rnd_bare", pb(P_HR - (kind - 3)), exp_arg, 0);
          else begin
            exp_arg = 7'(val);
            expect_out("rnd_set", pb(P_SH - (kind - 3)), exp_arg, 0);
          end
        end
      end else if (kind == 6) begin
        send(ws[$urandom_range(0, 2)]);
        expect_out("rnd_ws", 0, exp_arg, 1);
      end else begin
        send(bad[$urandom_range(0, 3)]);
        expect_out("rnd_bad", pb(P_ERR), exp_arg, 0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter ARG_DIGITS, default 2: maximum decimal digits in a set-command argument.
REQ-002 Parameter ARG_W, default 7: width of o_arg; SHALL satisfy 2^ARG_W > 10^ARG_DIGITS-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 100_000_000: idle cycles allowed between argument bytes.
REQ-004 Parameter CASE_INSENS, default 1: 1 = upper and lower case letters both accepted; 0 = upper case only.
REQ-005 One clock; reset is asynchronous and active-high. Ports: clk (in, 1, clock) and rst (in, 1, reset).
REQ-006 Port i_rx_data, in, 8: received ASCII byte.
REQ-007 Port i_rx_valid, in, 1: i_rx_data valid.
REQ-008 Port o_rx_ready, out, 1: parser can take a byte; a byte is accepted on a clk edge with i_rx_valid & o_rx_ready.
REQ-009 Ports o_run, o_clear, o_mode, out, 1 each: one-cycle command pulses.
REQ-010 Ports o_hour, o_min, o_sec, out, 1 each: one-cycle increment pulses (bare H/M/S).
REQ-011 Ports o_set_hour, o_set_min, o_set_sec, out, 1 each: one-cycle load pulses qualified by o_arg.
REQ-012 Port o_arg, out, ARG_W: parsed argument, held until the next set command.
REQ-013 Port o_err, out, 1: one-cycle pulse on a malformed command or a timeout.

Function
REQ-014 FSM states: IDLE, GET_ARG, EXEC, ERR. All outputs SHALL be registered.
REQ-015 IDLE: an accepted 'R', 'C' or 'X' SHALL go to EXEC and assert o_run, o_clear or o_mode respectively.
REQ-016 IDLE: an accepted 'H', 'M' or 'S' SHALL latch the target, clear the accumulator and digit count, and go to GET_ARG.
REQ-017 IDLE: accepted CR (0x0D), LF (0x0A) and space (0x20) SHALL be discarded with no pulse; any other byte SHALL go to ERR.
REQ-018 Lower-case letters SHALL be treated as their upper-case equivalents when CASE_INSENS=1, and SHALL go to ERR when CASE_INSENS=0.
REQ-019 GET_ARG, digit '0'-'9' with count<ARG_DIGITS: acc = acc*10 + digit, count+1. The intermediate product is ARG_W+4 bits and is truncated to ARG_W.
REQ-020 GET_ARG, digit with count==ARG_DIGITS: go to ERR (overflow).
REQ-021 GET_ARG, CR or LF with count==0: go to EXEC and pulse o_hour, o_min or o_sec per the target.
REQ-022 GET_ARG, CR or LF with count>0: go to EXEC, load o_arg=acc and pulse o_set_hour, o_set_min or o_set_sec in the same cycle.
REQ-023 GET_ARG, any other byte: go to ERR.
REQ-024 Timeout counter: clears on entry to GET_ARG and on each accepted byte, increments otherwise. At TIMEOUT_CYCLES-1 it SHALL force ERR. If a byte is accepted in the same cycle, the byte SHALL take priority.
REQ-025 EXEC and ERR SHALL last exactly one cycle, then return to IDLE. o_rx_ready=0 in both states and 1 in IDLE and GET_ARG.
REQ-026 Latency: a pulse SHALL be asserted in the cycle immediately after the accepting edge, and for exactly one cycle.
REQ-027 At most one pulse output SHALL be high in any cycle.

Reset
REQ-028 On rst: state=IDLE, all pulses=0, o_arg=0, accumulator, digit count and timer=0, o_rx_ready=1 (IDLE). A reset during GET_ARG SHALL discard the partial command with no o_err.

Structure
REQ-029 Shared package uart_cmd_pkg SHALL hold the state enumeration, the ASCII constants (CR, LF, SP, command letters) and the target-select encoding.
REQ-030 The timeout counter SHALL be a sub-module uart_cmd_timer (params TIMEOUT_CYCLES; ports clk, rst, clr, en, expired).

Verification
REQ-031 'r' -> o_run high exactly one cycle after acceptance; o_rx_ready low that cycle.
REQ-032 'S','4','2',CR -> o_set_sec pulse with o_arg=42; o_arg still 42 after 10 idle cycles.
REQ-033 'h',CR -> single o_hour pulse; o_set_hour stays 0; o_arg unchanged.
REQ-034 'M','1','2','3' -> o_err on the third digit; a following 'C' -> o_clear.
REQ-035 'H','5' then no bytes for TIMEOUT_CYCLES (bench override 16) -> o_err; a byte on the expiry cycle -> no o_err.
REQ-036 'Q' -> o_err. CASE_INSENS=0 with 'x' -> o_err. rst asserted after 'S','7' -> no pulses and o_arg=0.
